// File: rtl/dht11_transceiver.sv
// dht11_transceiver: single-wire host controller for DHT11-class sensors.
// Ports: clock, reset (async, active-high); start (1-cycle read request);
//   read_in (raw line level from pad); direction/send_out (pad drive control);
//   busy, done, error_code (0 ok, 1 no response, 2 bit timeout, 3 checksum);
//   hum_int, hum_dec, temp_int, temp_dec, checksum (last good frame bytes).
// Option: define CHECKSUM_CHECK_EN to reject frames whose checksum byte mismatches.
module dht11_transceiver #(
  parameter int CYCLES_PER_US = 50,
  parameter int START_LOW_US = 18000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       read_in,
  output logic       direction,
  output logic       send_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] error_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic [7:0] checksum
);
  localparam int PW = CYCLES_PER_US > 1 ? $clog2(CYCLES_PER_US) : 1;
  typedef enum logic [2:0] {IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, FINISH} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [15:0] us, us_n;
  logic s1, s2, prev;
  logic [5:0] bit_cnt;
  logic [38:0] shreg;
  logic [39:0] frame;
  logic [1:0] err_n;
  logic tick, fall, rise, timeout, start_done, bit_v, sum_bad;
  assign tick = presc == PW'(CYCLES_PER_US - 1);
  assign us_n = (tick && us != 16'hffff) ? us + 16'd1 : us;
  // Limits compare against the post-increment count so a phase lasts exactly N us from entry.
  assign timeout = us_n >= 16'(TIMEOUT_US);
  assign start_done = us_n >= 16'(START_LOW_US);
  assign fall = prev & ~s2;
  assign rise = ~prev & s2;
  assign bit_v = us > 16'(BIT_THRESH_US);
  assign frame = {shreg, bit_v};
`ifdef CHECKSUM_CHECK_EN
  assign sum_bad = (frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8]) != frame[7:0];
`else
  assign sum_bad = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    err_n = 2'd0;
    direction = state == START_LOW;
    send_out = 1'b0;
    busy = state != IDLE && state != FINISH;
    done = state == FINISH;
    case (state)
      IDLE: state_n = start ? START_LOW : IDLE;
      START_LOW: state_n = start_done ? RELEASE : START_LOW;
      RELEASE: begin
        state_n = fall ? RESP_LOW : timeout ? FINISH : RELEASE;
        err_n = fall ? 2'd0 : 2'd1;
      end
      RESP_LOW: begin
        state_n = rise ? RESP_HIGH : timeout ? FINISH : RESP_LOW;
        err_n = rise ? 2'd0 : 2'd1;
      end
      RESP_HIGH: begin
        state_n = fall ? BIT_LOW : timeout ? FINISH : RESP_HIGH;
        err_n = fall ? 2'd0 : 2'd1;
      end
      BIT_LOW: begin
        state_n = rise ? BIT_HIGH : timeout ? FINISH : BIT_LOW;
        err_n = rise ? 2'd0 : 2'd2;
      end
      BIT_HIGH: begin
        state_n = fall ? (bit_cnt == 6'd39 ? FINISH : BIT_LOW) : timeout ? FINISH : BIT_HIGH;
        err_n = fall ? (sum_bad ? 2'd3 : 2'd0) : 2'd2;
      end
      FINISH: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {s1, s2, prev} <= 3'b111;
      presc <= '0;
      us <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      error_code <= '0;
      {hum_int, hum_dec, temp_int, temp_dec, checksum} <= '0;
    end else begin
      {s1, s2, prev} <= {read_in, s1, s2};
      presc <= (state_n != state || tick) ? '0 : presc + PW'(1);
      us <= state_n != state ? '0 : us_n;
      if (state == RESP_HIGH && fall) bit_cnt <= '0;
      if (state == BIT_HIGH && fall) begin
        shreg <= frame[38:0];
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (state_n == FINISH) begin
        error_code <= err_n;
        if (err_n == 2'd0) {hum_int, hum_dec, temp_int, temp_dec, checksum} <= frame;
      end
    end
endmodule
